// File: rtl/plotter_pkg.sv
// Shared definitions for the plotting pipeline.
//   coord_width : bits needed to address a screen dimension
//   err_width   : width of the signed Bresenham error terms (dx, dy, err, e2).
//                 Two bits over the widest coordinate leave room for the
//                 sign and for doubling err without overflow.
//   line_state_t: line_drawer FSM states
package plotter_pkg;

    function automatic int coord_width(input int pixels);
        return (pixels > 1) ? $clog2(pixels) : 1;
    endfunction

    function automatic int err_width(input int x_width, input int y_width);
        return ((x_width > y_width) ? x_width : y_width) + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } line_state_t;

endpackage

// File: rtl/line_step.sv
// One combinational Bresenham step.
//   err, dx, dy      : signed error state (dx >= 0, dy <= 0)
//   sx_neg, sy_neg   : 1 = step towards smaller x / y
//   cur_x/y, end_x/y : current pixel and line end point
//   next_err/x/y     : state after stepping from the current pixel
//   done             : current pixel is the end point
module line_step
    import plotter_pkg::*;
#(
    parameter int X_WIDTH   = 10,
    parameter int Y_WIDTH   = 9,
    parameter int ERR_WIDTH = 12
)(
    input  logic signed [ERR_WIDTH-1:0] err,
    input  logic signed [ERR_WIDTH-1:0] dx,
    input  logic signed [ERR_WIDTH-1:0] dy,
    input  logic                        sx_neg,
    input  logic                        sy_neg,
    input  logic [X_WIDTH-1:0]          cur_x,
    input  logic [Y_WIDTH-1:0]          cur_y,
    input  logic [X_WIDTH-1:0]          end_x,
    input  logic [Y_WIDTH-1:0]          end_y,
    output logic signed [ERR_WIDTH-1:0] next_err,
    output logic [X_WIDTH-1:0]          next_x,
    output logic [Y_WIDTH-1:0]          next_y,
    output logic                        done
);

    logic signed [ERR_WIDTH-1:0] e2;
    logic                        step_x;
    logic                        step_y;

    always_comb begin
        e2       = err <<< 1;
        // Both tests use the error from before this step, so a diagonal
        // move applies dy and dx together.
        step_x   = (e2 >= dy);
        step_y   = (e2 <= dx);
        next_err = err;
        next_x   = cur_x;
        next_y   = cur_y;
        if (step_x) begin
            next_err = next_err + dy;
            next_x   = sx_neg ? cur_x - X_WIDTH'(1) : cur_x + X_WIDTH'(1);
        end
        if (step_y) begin
            next_err = next_err + dx;
            next_y   = sy_neg ? cur_y - Y_WIDTH'(1) : cur_y + Y_WIDTH'(1);
        end
        done = (cur_x == end_x) && (cur_y == end_y);
    end

endmodule

// File: rtl/line_drawer.sv
// Bresenham line rasteriser, all octants.
//   clk, rst            : clock, synchronous active-high reset
//   start, ready        : line request / idle handshake from the controller
//   x1, y1, x2, y2      : endpoints, latched when start is accepted
//   pixel_x, pixel_y    : current pixel, valid while pixel_write is high
//   pixel_write         : pixel offered to the framebuffer
//   pixel_ready         : framebuffer takes the pixel this cycle
// Timing: start accepted in cycle T, first pixel at T+2, one pixel per
// accepted handshake, ready again the cycle after the end point is taken.
module line_drawer
    import plotter_pkg::*;
#(
    parameter int  HOR_ACTIVE_PIXELS = 640,
    parameter int  VER_ACTIVE_PIXELS = 480,
    localparam int X_WIDTH = coord_width(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH = coord_width(VER_ACTIVE_PIXELS)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y2,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               pixel_write,
    input  logic               pixel_ready
);

    localparam int ERR_WIDTH = err_width(X_WIDTH, Y_WIDTH);

    line_state_t                 state_reg, state_next;
    logic [X_WIDTH-1:0]          cur_x_reg, end_x_reg;
    logic [Y_WIDTH-1:0]          cur_y_reg, end_y_reg;
    logic signed [ERR_WIDTH-1:0] dx_reg, dy_reg, err_reg;
    logic                        sx_neg_reg, sy_neg_reg;

    // Setup-phase terms derived from the latched endpoints
    logic [X_WIDTH-1:0]          abs_dx;
    logic [Y_WIDTH-1:0]          abs_dy;
    logic signed [ERR_WIDTH-1:0] setup_dx, setup_dy;

    // Step results
    logic signed [ERR_WIDTH-1:0] step_err;
    logic [X_WIDTH-1:0]          step_x;
    logic [Y_WIDTH-1:0]          step_y;
    logic                        step_done;

    assign abs_dx   = (end_x_reg > cur_x_reg) ? end_x_reg - cur_x_reg : cur_x_reg - end_x_reg;
    assign abs_dy   = (end_y_reg > cur_y_reg) ? end_y_reg - cur_y_reg : cur_y_reg - end_y_reg;
    assign setup_dx = $signed(ERR_WIDTH'(abs_dx));
    assign setup_dy = -$signed(ERR_WIDTH'(abs_dy));

    line_step #(
        .X_WIDTH   (X_WIDTH),
        .Y_WIDTH   (Y_WIDTH),
        .ERR_WIDTH (ERR_WIDTH)
    ) u_step (
        .err      (err_reg),
        .dx       (dx_reg),
        .dy       (dy_reg),
        .sx_neg   (sx_neg_reg),
        .sy_neg   (sy_neg_reg),
        .cur_x    (cur_x_reg),
        .cur_y    (cur_y_reg),
        .end_x    (end_x_reg),
        .end_y    (end_y_reg),
        .next_err (step_err),
        .next_x   (step_x),
        .next_y   (step_y),
        .done     (step_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ready       = 1'b0;
        pixel_write = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = DRAW;
            end
            DRAW: begin
                pixel_write = 1'b1;
                if (pixel_ready && step_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pixel outputs come straight from the position registers, which only
    // move on an accepted handshake, so they hold steady through stalls.
    assign pixel_x = cur_x_reg;
    assign pixel_y = cur_y_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x_reg  <= '0;
            cur_y_reg  <= '0;
            end_x_reg  <= '0;
            end_y_reg  <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            err_reg    <= '0;
            sx_neg_reg <= 1'b0;
            sy_neg_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cur_x_reg <= x1;
                        cur_y_reg <= y1;
                        end_x_reg <= x2;
                        end_y_reg <= y2;
                    end
                end
                SETUP: begin
                    dx_reg     <= setup_dx;
                    dy_reg     <= setup_dy;
                    err_reg    <= setup_dx + setup_dy;
                    sx_neg_reg <= !(cur_x_reg < end_x_reg);
                    sy_neg_reg <= !(cur_y_reg < end_y_reg);
                end
                DRAW: begin
                    if (pixel_ready && !step_done) begin
                        cur_x_reg <= step_x;
                        cur_y_reg <= step_y;
                        err_reg   <= step_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
